line_buffer_taps: RTL

// - Parametrised multi-line video buffer for windowed filters (Sobel, erosion, tracker windows).
// - Generalised, enable-driven line delay: NUM_LINES line taps, each exactly LINE_LEN pixel beats apart.
// - Uses one wide BRAM circular buffer instead of a chain of shift registers, and never gates the clock.
// - Adds fill tracking, a per-tap validity mask, and frame-start resync.

---
 rtl/line_buffer_taps_pkg.sv | 19 +
 rtl/line_buffer_taps_if.sv | 27 ++
 rtl/line_buffer_taps_sdp_ram.sv | 32 +++
 rtl/line_buffer_taps.sv | 119 +++++++++++
 4 files changed

// File: rtl/line_buffer_taps_pkg.sv
// Shared defaults and helpers for the multi-line tap buffer.
// Imported by the interface, the RAM wrapper and the top level.
package line_buffer_taps_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_LINE_LEN  = 800;
  localparam int DEF_NUM_LINES = 5;
  localparam int MAX_LANES     = 32;

  // Thermometer mask: bit k set when fill > k (lane k holds a full line of history).
  function automatic logic [MAX_LANES-1:0] thermo_mask(input logic [31:0] fill);
    logic [MAX_LANES-1:0] m;
    for (int i = 0; i < MAX_LANES; i++) begin
      m[i] = (fill > 32'(i));
    end
    return m;
  endfunction

endpackage

// File: rtl/line_buffer_taps_if.sv
// Pixel-stream and tap-output bundle for line_buffer_taps.
// master drives the pixel stream; slave (the buffer) drives the taps.
interface line_buffer_taps_if #(
  parameter int DATA_W    = 16,
  parameter int LINE_LEN  = 800,
  parameter int NUM_LINES = 5
);
  localparam int ADDR_W = $clog2(LINE_LEN);

  logic                        clken;
  logic                        sof;
  logic [DATA_W-1:0]           shiftin;
  logic [NUM_LINES*DATA_W-1:0] taps;
  logic [NUM_LINES-1:0]        tap_valid;
  logic                        out_valid;
  logic [ADDR_W-1:0]           col_idx;

  modport master (
    output clken, sof, shiftin,
    input  taps, tap_valid, out_valid, col_idx
  );

  modport slave (
    input  clken, sof, shiftin,
    output taps, tap_valid, out_valid, col_idx
  );
endinterface

// File: rtl/line_buffer_taps_sdp_ram.sv
// Simple-dual-port RAM, registered read-first read port, no reset.
// One word per column holds every line lane for that column.
module line_buffer_taps_sdp_ram #(
  parameter int WIDTH  = 80,
  parameter int DEPTH  = 800,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Read-first: a same-address write in this cycle is not visible on the read.
  always_ff @(posedge clk) begin
    if (re) begin
      rd_data_r <= mem_r[raddr];
    end
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = rd_data_r;

endmodule

// File: rtl/line_buffer_taps.sv
// Multi-line video tap buffer: lane k delays the pixel stream by (k+1)*LINE_LEN beats,
// using one circular RAM word per column plus fill tracking and frame-start resync.
module line_buffer_taps
  import line_buffer_taps_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LINE_LEN  = DEF_LINE_LEN,
  parameter int NUM_LINES = DEF_NUM_LINES
) (
  input logic clk,
  input logic rst,
  line_buffer_taps_if.slave bus
);

  localparam int ADDR_W = $clog2(LINE_LEN);
  localparam int FILL_W = $clog2(NUM_LINES + 1);
  localparam int WORD_W = DATA_W * NUM_LINES;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_LEN - 1);
  localparam logic [ADDR_W-1:0] COL_ONE  = ADDR_W'(1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_LINES);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

  logic [ADDR_W-1:0]    col_r;
  logic [ADDR_W-1:0]    col_eff_s;
  logic [ADDR_W-1:0]    col_next_s;
  logic [FILL_W-1:0]    fill_r;
  logic [FILL_W-1:0]    fill_beat_s;
  logic [FILL_W-1:0]    fill_next_s;
  logic [MAX_LANES-1:0] mask_wide_s;
  logic [NUM_LINES-1:0] beat_mask_s;

  logic                 s1_valid_r;
  logic [ADDR_W-1:0]    s1_col_r;
  logic [DATA_W-1:0]    s1_pix_r;
  logic [NUM_LINES-1:0] tap_valid_r;

  logic [WORD_W-1:0]    rd_data_s;
  logic [WORD_W-1:0]    wr_data_s;
  logic [WORD_W-1:0]    taps_s;

  // Stage-0 address, next column and fill; sof restarts both at zero.
  always_comb begin
    col_eff_s   = bus.sof ? {ADDR_W{1'b0}} : col_r;
    col_next_s  = (col_eff_s == LAST_COL) ? {ADDR_W{1'b0}} : (col_eff_s + COL_ONE);
    fill_beat_s = bus.sof ? {FILL_W{1'b0}} : fill_r;
    if (bus.sof) begin
      fill_next_s = {FILL_W{1'b0}};
    end else if ((col_eff_s == LAST_COL) && (fill_r != FILL_MAX)) begin
      fill_next_s = fill_r + FILL_ONE;
    end else begin
      fill_next_s = fill_r;
    end
    mask_wide_s = thermo_mask(32'(fill_beat_s));
    beat_mask_s = mask_wide_s[NUM_LINES-1:0];
  end

  // Column/fill counters and stage-1 pipeline registers, all advanced only on clken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r       <= {ADDR_W{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      s1_valid_r  <= 1'b0;
      s1_col_r    <= {ADDR_W{1'b0}};
      s1_pix_r    <= {DATA_W{1'b0}};
      tap_valid_r <= {NUM_LINES{1'b0}};
    end else begin
      s1_valid_r <= bus.clken;
      if (bus.clken) begin
        col_r       <= col_next_s;
        fill_r      <= fill_next_s;
        s1_col_r    <= col_eff_s;
        s1_pix_r    <= bus.shiftin;
        tap_valid_r <= beat_mask_s;
      end
    end
  end

  line_buffer_taps_sdp_ram #(
    .WIDTH  (WORD_W),
    .DEPTH  (LINE_LEN),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (s1_valid_r),
    .waddr (s1_col_r),
    .wdata (wr_data_s),
    .re    (bus.clken),
    .raddr (col_eff_s),
    .rdata (rd_data_s)
  );

  // Each lane moves up one line on write-back; the oldest lane falls off the top.
  generate
    if (NUM_LINES > 1) begin : g_shift
      assign wr_data_s = {rd_data_s[(NUM_LINES-1)*DATA_W-1:0], s1_pix_r};
    end else begin : g_single
      assign wr_data_s = s1_pix_r;
    end
  endgenerate

  // Lanes without a full line of current-frame history read as zero.
  always_comb begin
    taps_s = {WORD_W{1'b0}};
    for (int k = 0; k < NUM_LINES; k++) begin
      if (tap_valid_r[k]) begin
        taps_s[k*DATA_W +: DATA_W] = rd_data_s[k*DATA_W +: DATA_W];
      end else begin
        taps_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  assign bus.taps      = taps_s;
  assign bus.tap_valid = tap_valid_r;
  assign bus.out_valid = s1_valid_r;
  assign bus.col_idx   = s1_col_r;

endmodule
